// File: rtl/z80_bus_tracer.sv
// Z80 bus tracer: turns qualified CPU bus cycles into {type, addr, data} records held in a FIFO.
// Define TRACE_TIMESTAMP_EN to stamp each record with a 16-bit cen-cycle counter on port rec_ts.
module z80_bus_tracer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cen,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  di,
  input  logic [7:0]  dout,
  input  logic        pop,
  input  logic        clr,
  output logic        rec_valid,
  output logic [26:0] rec_data,
  output logic [8:0]  rec_count,
  output logic        overflow,
  output logic [7:0]  drop_cnt
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [15:0] rec_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int RW = 43;
`else
  localparam int RW = 27;
`endif
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, next_state;
  logic          qual;
  logic [2:0]    qual_type;
  logic [7:0]    qual_data;
  logic          load, relatch, push;
  logic [2:0]    cur_type;
  logic [15:0]   cur_addr;
  logic [7:0]    cur_data;
  logic [RW-1:0] push_rec;
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [8:0]    count;
  logic          full, do_pop, do_push, drop;

  // Strobe decode; earlier entries win when several patterns overlap.
  always_comb begin
    qual      = 1'b0;
    qual_type = 3'd0;
    if (rfsh_n) begin
      if (!m1_n && !mreq_n && !rd_n) begin
        qual = 1'b1; qual_type = 3'd0;
      end else if (m1_n && !mreq_n && !rd_n) begin
        qual = 1'b1; qual_type = 3'd1;
      end else if (!mreq_n && !wr_n) begin
        qual = 1'b1; qual_type = 3'd2;
      end else if (m1_n && !iorq_n && !rd_n) begin
        qual = 1'b1; qual_type = 3'd3;
      end else if (!iorq_n && !wr_n) begin
        qual = 1'b1; qual_type = 3'd4;
      end else if (!m1_n && !iorq_n) begin
        qual = 1'b1; qual_type = 3'd5;
      end
    end
  end

  assign qual_data = (qual_type == 3'd2 || qual_type == 3'd4) ? dout : di;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    relatch    = 1'b0;
    push       = 1'b0;
    if (cen) begin
      case (state)
        IDLE: begin
          if (qual) begin
            next_state = ACTIVE;
            load       = 1'b1;
          end
        end
        ACTIVE: begin
          if (!qual) begin
            next_state = IDLE;
            push       = 1'b1;
          end else if (qual_type != cur_type) begin
            // Back-to-back cycles of different kinds: close the old record, open the new one.
            push = 1'b1;
            load = 1'b1;
          end else begin
            relatch = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_type <= 3'd0;
      cur_addr <= 16'd0;
      cur_data <= 8'd0;
    end else begin
      if (load) begin
        cur_type <= qual_type;
        cur_addr <= A;
      end
      if (load || relatch) cur_data <= qual_data;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_cnt, cur_ts;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= 16'd0;
      cur_ts <= 16'd0;
    end else begin
      if (load) cur_ts <= ts_cnt;
      if (cen)  ts_cnt <= ts_cnt + 16'd1;
    end
  end

  assign push_rec = {cur_ts, cur_type, cur_addr, cur_data};
  assign rec_ts   = rec_valid ? mem[rd_ptr][42:27] : 16'd0;
`else
  assign push_rec = {cur_type, cur_addr, cur_data};
`endif

  assign full    = (count == 9'(DEPTH));
  assign do_pop  = pop && (count != 9'd0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 9'd0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 9'd0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + 9'd1;
      else if (!do_push && do_pop) count <= count - 9'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_rec;
  end

  assign rec_valid = (count != 9'd0);
  assign rec_count = count;
  assign rec_data  = rec_valid ? mem[rd_ptr][26:0] : 27'd0;

endmodule
